terminal_char_scheduler: RTL and testbench

//  Sequences character writes into the Apple 1 video terminal core. Arbitrates two

---
 rtl/term_sched_pkg.sv | 19 +
 rtl/term_char_fifo.sv | 56 +++++
 rtl/terminal_char_scheduler.sv | 169 ++++++++++++++++
 tb/tb_terminal_char_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_sched_pkg.sv
// rtl/term_sched_pkg.sv - shared types and constants for the terminal character scheduler
package term_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [6:0] ASCII_LC_A  = 7'h61;
    localparam logic [6:0] ASCII_LC_Z  = 7'h7A;
    localparam logic [6:0] CASE_OFFSET = 7'h20;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/term_char_fifo.sv
// rtl/term_char_fifo.sv - synchronous 7-bit character FIFO with occupancy count
module term_char_fifo
    import term_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [6:0]                    push_data,
    input  logic                          pop,
    output logic [6:0]                    pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/terminal_char_scheduler.sv
// rtl/terminal_char_scheduler.sv - arbitrates two character sources into the video terminal handshake
module terminal_char_scheduler
    import term_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CLR_CYCLES     = 1600000,
    parameter bit UPCASE         = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               a_valid,
    input  logic [6:0]                         a_data,
    output logic                               a_ready,
    input  logic                               b_valid,
    input  logic [6:0]                         b_data,
    output logic                               b_ready,
    input  logic                               clr_req,
    input  logic                               rda_n,
    output logic [6:0]                         rd,
    output logic                               da,
    output logic                               clr_out,
    output logic                               busy,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic                               timeout_err
);

    localparam int LW   = level_width(FIFO_DEPTH);
    localparam int TMAX = (TIMEOUT_CYCLES > CLR_CYCLES) ? TIMEOUT_CYCLES : CLR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] CLR_LAST = TW'(CLR_CYCLES - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [6:0]    rd_next;
    logic          da_next, clr_next, err_next, clr_take;
    logic          rda_meta, rda_sync;
    logic          rr_last, rr_after;   // 1: B was served last
    logic          clr_pend;
    logic          accept_a, accept_b, push, pop;
    logic [6:0]    push_data, fifo_head;
    logic          fifo_full, fifo_empty;
    logic [LW:0]   level_after;
    logic          room, gnt_a, gnt_b;

    function automatic logic [6:0] fold_case(input logic [6:0] c);
        if (UPCASE && c >= ASCII_LC_A && c <= ASCII_LC_Z) return c - CASE_OFFSET;
        return c;
    endfunction

    assign accept_a  = a_valid && a_ready;
    assign accept_b  = b_valid && b_ready;
    assign push      = accept_a || accept_b;
    assign push_data = fold_case(accept_a ? a_data : b_data);
    assign busy      = (state != IDLE) || !fifo_empty;

    term_char_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Grants are registered, so room is judged on the occupancy after this edge.
    always_comb begin
        level_after = {1'b0, fifo_level} + (LW+1)'(push) - (LW+1)'(pop);
        room        = !(fifo_full && !pop) && (level_after < (LW+1)'(FIFO_DEPTH))
                      && (state_next != CLEAR);
        rr_after    = accept_a ? 1'b0 : (accept_b ? 1'b1 : rr_last);
        if (a_valid && b_valid) begin
            gnt_a = room && rr_after;
            gnt_b = room && !rr_after;
        end else begin
            gnt_a = room && a_valid;
            gnt_b = room && b_valid;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = (state == IDLE) ? '0 : timer + TW'(1);
        pop        = 1'b0;
        rd_next    = rd;
        da_next    = da;
        clr_next   = clr_out;
        err_next   = timeout_err;
        clr_take   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    state_next = CLEAR;
                    clr_next   = 1'b1;
                    clr_take   = 1'b1;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    rd_next    = fifo_head;
                    da_next    = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (!rda_sync) begin
                    da_next    = 1'b0;
                    state_next = RELEASE;
                    timer_next = '0;
                end else if (timer >= TO_LAST) begin
                    da_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = RELEASE;
                    timer_next = '0;
                end
            end
            RELEASE: begin
                if (rda_sync) begin
                    state_next = IDLE;
                end else if (timer >= TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (timer >= CLR_LAST) begin
                    clr_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            rd          <= '0;
            da          <= 1'b0;
            clr_out     <= 1'b0;
            timeout_err <= 1'b0;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
            rr_last     <= 1'b1;
            clr_pend    <= 1'b0;
            rda_meta    <= 1'b1;
            rda_sync    <= 1'b1;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            rd          <= rd_next;
            da          <= da_next;
            clr_out     <= clr_next;
            timeout_err <= err_next;
            a_ready     <= gnt_a;
            b_ready     <= gnt_b;
            rr_last     <= rr_after;
            clr_pend    <= clr_req || (clr_pend && !clr_take);
            rda_meta    <= rda_n;
            rda_sync    <= rda_meta;
        end
    end

endmodule

// File: tb/tb_terminal_char_scheduler.sv
// tb/tb_terminal_char_scheduler.sv - randomized self-checking bench for terminal_char_scheduler
module tb_terminal_char_scheduler;

    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int CLR   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0, clr_req = 1'b0, rda_n = 1'b1;
    logic [6:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, da, clr_out, busy, timeout_err;
    logic [6:0] rd;
    logic [2:0] fifo_level;
    logic       a_ready_lc, b_ready_lc, da_lc, clr_out_lc, busy_lc, timeout_err_lc;
    logic [6:0] rd_lc;
    logic [2:0] fifo_level_lc;

    always #5 clk = ~clk;

    terminal_char_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CLR_CYCLES(CLR), .UPCASE(1'b1)) dut (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .clr_req(clr_req), .rda_n(rda_n),
        .rd(rd), .da(da), .clr_out(clr_out), .busy(busy), .fifo_level(fifo_level),
        .timeout_err(timeout_err)
    );

    terminal_char_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CLR_CYCLES(CLR), .UPCASE(1'b0)) dut_lc (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_lc),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_lc), .clr_req(clr_req), .rda_n(rda_n),
        .rd(rd_lc), .da(da_lc), .clr_out(clr_out_lc), .busy(busy_lc), .fifo_level(fifo_level_lc),
        .timeout_err(timeout_err_lc)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] up(input logic [6:0] c);
        return (c >= 7'h61 && c <= 7'h7A) ? c - 7'h20 : c;
    endfunction

    logic [6:0] a_src[$], b_src[$], exp_q[$], raw_q[$];
    int         src_log[$];
    int cyc, acc_cnt, rise_cnt, last_acc_cyc, last_rise_cyc;
    int da_len, last_da_len, clr_len, clr_starts, rise_at_clr, max_level, ack_dly, rel_dly;
    bit tm_enable = 1'b1, rnd_term = 1'b0, a_dense = 1'b1, b_dense = 1'b1;
    logic       da_prev = 1'b0, clr_prev = 1'b0;
    logic [6:0] held_rd, e_rd, e_raw;

    // Source drivers: present the head of each source queue.
    always @(posedge clk) begin
        #1;
        a_valid = (a_src.size() > 0) && (a_dense || ($urandom_range(0, 1) == 1));
        a_data  = (a_src.size() > 0) ? a_src[0] : 7'h0;
        b_valid = (b_src.size() > 0) && (b_dense || ($urandom_range(0, 1) == 1));
        b_data  = (b_src.size() > 0) ? b_src[0] : 7'h0;
    end

    // Reference model, scoreboard and terminal acknowledge model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            a_src.delete(); b_src.delete(); exp_q.delete(); raw_q.delete();
            acc_cnt = 0; rise_cnt = 0; ack_dly = 0; rel_dly = 0;
            rda_n = 1'b1; da_prev = 1'b0; clr_prev = 1'b0; da_len = 0; clr_len = 0;
        end else begin
            check_eq("rdy_excl", 32'(a_ready & b_ready), 0);
            if (da && !da_prev) begin
                rise_cnt++;
                last_rise_cyc = cyc;
                da_len = 1;
                held_rd = rd;
                if (exp_q.size() == 0) begin
                    check_eq("rd_spurious", exp_q.size(), 1);
                end else begin
                    e_rd  = exp_q.pop_front();
                    e_raw = raw_q.pop_front();
                    check_eq("rd", rd, e_rd);
                    check_eq("rd_raw", rd_lc, e_raw);
                end
                if (tm_enable) ack_dly = rnd_term ? int'($urandom_range(1, 6)) : 5;
            end else if (da) begin
                da_len++;
                check_eq("rd_hold", rd, held_rd);
                if (ack_dly > 0) begin
                    ack_dly--;
                    if (ack_dly == 0) rda_n = 1'b0;
                end
            end
            if (!da && da_prev) begin
                last_da_len = da_len;
                if (!rda_n) rel_dly = rnd_term ? int'($urandom_range(1, 4)) : 3;
            end else if (rel_dly > 0) begin
                rel_dly--;
                if (rel_dly == 0) rda_n = 1'b1;
            end
            check_eq("level", fifo_level, acc_cnt - rise_cnt);
            if (int'(fifo_level) > max_level) max_level = fifo_level;
            if (clr_out) begin
                check_eq("clr_no_da", da, 0);
                if (!clr_prev) begin
                    clr_starts++;
                    rise_at_clr = rise_cnt;
                    clr_len = 0;
                end
                clr_len++;
            end else if (clr_prev) begin
                check_eq("clr_len", clr_len, CLR);
            end
            if (a_valid && a_ready) begin
                e_raw = a_src.pop_front();
                exp_q.push_back(up(e_raw)); raw_q.push_back(e_raw); src_log.push_back(0);
                acc_cnt++; last_acc_cyc = cyc;
            end
            if (b_valid && b_ready) begin
                e_raw = b_src.pop_front();
                exp_q.push_back(up(e_raw)); raw_q.push_back(e_raw); src_log.push_back(1);
                acc_cnt++; last_acc_cyc = cyc;
            end
            da_prev  = da;
            clr_prev = clr_out;
        end
    end

    task automatic wait_rise(input string tag, input int target, input int maxc);
        int i = 0;
        while (rise_cnt < target && i < maxc) begin
            @(negedge clk); #1; i++;
        end
        if (rise_cnt < target) check_eq({tag, "_rise_tmo"}, rise_cnt, target);
    endtask

    task automatic drain(input string tag, input int maxc);
        int i = 0;
        int stable = 0;
        while (stable < 4 && i < maxc) begin
            @(negedge clk); #1; i++;
            if (a_src.size() == 0 && b_src.size() == 0 && !busy && !clr_req
                && rda_n && ack_dly == 0 && rel_dly == 0) stable++;
            else stable = 0;
        end
        if (stable < 4) check_eq({tag, "_drain_tmo"}, stable, 4);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, cs;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_b_ready", b_ready, 0);
        check_eq("rst_rd", rd, 0);
        check_eq("rst_da", da, 0);
        check_eq("rst_clr_out", clr_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_err", timeout_err, 0);

        // Reset in the middle of a handshake with chars still queued.
        a_src.push_back(7'h55); a_src.push_back(7'h56); a_src.push_back(7'h57);
        wait_rise("t1", 1, 30);
        repeat (2) @(negedge clk);
        check_eq("t1_pre_level", fifo_level, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check_eq("t1_da", da, 0);
        check_eq("t1_rd", rd, 0);
        check_eq("t1_level", fifo_level, 0);
        check_eq("t1_err", timeout_err, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Both requesters streaming: strict alternation starting with A.
        src_log.delete(); max_level = 0; base = rise_cnt;
        for (int i = 0; i < 8; i++) begin
            a_src.push_back(7'($urandom_range(0, 127)));
            b_src.push_back(7'($urandom_range(0, 127)));
        end
        drain("t3", 800);
        check_eq("t3_count", rise_cnt - base, 16);
        check_eq("t3_log", src_log.size(), 16);
        for (int i = 0; i < src_log.size(); i++) check_eq("t3_order", src_log[i], i % 2);
        check_eq("t3_maxlvl", max_level, DEPTH);
        check_eq("t3_lost", exp_q.size(), 0);

        // Single character latency from an empty, idle scheduler.
        base = rise_cnt;
        a_src.push_back(7'h41);
        wait_rise("t2", base + 1, 20);
        check_eq("t2_lat", last_rise_cyc - last_acc_cyc, 2);
        check_eq("t2_rd", rd, 7'h41);
        check_eq("t2_busy", busy, 1);
        drain("t2", 100);

        // Case folding boundaries through requester B.
        base = rise_cnt;
        b_src.push_back(7'h61); b_src.push_back(7'h7A); b_src.push_back(7'h7B); b_src.push_back(7'h40);
        drain("t4", 300);
        check_eq("t4_count", rise_cnt - base, 4);

        // Clear requested while a char is being presented.
        base = rise_cnt; cs = clr_starts;
        for (int i = 0; i < 3; i++) a_src.push_back(7'($urandom_range(32, 126)));
        wait_rise("t5", base + 1, 30);
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
        drain("t5", 400);
        check_eq("t5_clears", clr_starts - cs, 1);
        check_eq("t5_clr_after", rise_at_clr - base, 1);
        check_eq("t5_count", rise_cnt - base, 3);

        // Terminal never acknowledges: forced abort and sticky error.
        check_eq("t6_err0", timeout_err, 0);
        tm_enable = 1'b0; base = rise_cnt;
        a_src.push_back(7'h5A);
        wait_rise("t6", base + 1, 30);
        for (int i = 0; i < 40 && da; i++) begin
            @(negedge clk); #1;
        end
        check_eq("t6_da_len", last_da_len, TO);
        check_eq("t6_err", timeout_err, 1);
        tm_enable = 1'b1;
        drain("t6a", 100);
        a_src.push_back(7'h2B);
        drain("t6b", 100);
        check_eq("t6_count", rise_cnt - base, 2);
        check_eq("t6_sticky", timeout_err, 1);

        // Randomized traffic, terminal timing and clear requests.
        rnd_term = 1'b1; a_dense = 1'b0; b_dense = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'($urandom_range(4, 12)); i++) a_src.push_back(7'($urandom_range(0, 127)));
            for (int i = 0; i < int'($urandom_range(4, 12)); i++) b_src.push_back(7'($urandom_range(0, 127)));
            for (int i = 0; i < 150; i++) begin
                @(posedge clk); #1;
                clr_req = ($urandom_range(0, 59) == 0);
            end
            clr_req = 1'b0;
            drain("rnd", 4000);
        end
        check_eq("rnd_empty", exp_q.size(), 0);
        check_eq("rnd_balance", rise_cnt, acc_cnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
